// File: rtl/mips_mem_pkg.sv
// Shared address map, read-select encoding and decode helper for the
// multicycle MIPS memory/IO responder.
package mips_mem_pkg;

    localparam logic [15:0] INPORT0_ADDR = 16'hFFF8;
    localparam logic [15:0] INPORT1_ADDR = 16'hFFFC;
    localparam logic [15:0] OUTPORT_ADDR = 16'hFFFC;

    typedef enum logic [1:0] {
        RD_RAM  = 2'd0,
        RD_IN0  = 2'd1,
        RD_IN1  = 2'd2,
        RD_ZERO = 2'd3
    } rd_sel_t;

    function automatic logic addr_in_ram(input logic [15:0] a, input int unsigned words);
        return 32'(a) < (words * 4);
    endfunction

endpackage

// File: rtl/ram_sync_1r1w.sv
// Single-clock word RAM, read-first, registered read port, no reset.
module ram_sync_1r1w #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WIDTH-1:0] rdata_q;

    // Read samples the pre-write contents, giving old data on a same-word collision.
    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_io.sv
// Memory-side responder: synchronous RAM plus memory-mapped in/out ports,
// read data valid one cycle after the address.
module mips_mem_io
    import mips_mem_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAM_WORDS = 256,
    parameter logic [15:0] IN0_ADDR  = INPORT0_ADDR,
    parameter logic [15:0] IN1_ADDR  = INPORT1_ADDR,
    parameter logic [15:0] OUT_ADDR  = OUTPORT_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             mem_write,
    input  logic [WIDTH-1:0] inport_data,
    input  logic             inport_en,
    input  logic             inport_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] outport
);

    localparam int unsigned AW = $clog2(RAM_WORDS);

    logic [15:0]      a16;
    logic             in_ram;
    logic [AW-1:0]    idx;
    rd_sel_t          sel_d, sel_q;
    logic [WIDTH-1:0] in0_q, in1_q, port_rd_d, port_rd_q, out_q;
    logic [WIDTH-1:0] ram_rdata;
    logic             unused_bits;

    assign a16         = addr[15:0];
    assign idx         = addr[AW+1:2];
    assign in_ram      = addr_in_ram(a16, RAM_WORDS);
    assign unused_bits = ^{addr[WIDTH-1:16], addr[1:0]};

    always_comb begin
        sel_d = RD_ZERO;
        if (in_ram)               sel_d = RD_RAM;
        else if (a16 == IN0_ADDR) sel_d = RD_IN0;
        else if (a16 == IN1_ADDR) sel_d = RD_IN1;
    end

    always_comb begin
        port_rd_d = '0;
        case (sel_d)
            RD_IN0:  port_rd_d = in0_q;
            RD_IN1:  port_rd_d = in1_q;
            default: port_rd_d = '0;
        endcase
    end

    // RAM write is deliberately not gated by rst; only registers are reset.
    ram_sync_1r1w #(.WIDTH(WIDTH), .WORDS(RAM_WORDS)) u_ram (
        .clk     (clk),
        .we_i    (mem_write && in_ram),
        .waddr_i (idx),
        .wdata_i (wr_data),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    // Port read value is latched at the same edge as the select, so a capture
    // in that cycle is seen only on the following read.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= RD_ZERO;
            port_rd_q <= '0;
            in0_q     <= '0;
            in1_q     <= '0;
            out_q     <= '0;
        end else begin
            sel_q     <= sel_d;
            port_rd_q <= port_rd_d;
            if (inport_en && !inport_sel) in0_q <= inport_data;
            if (inport_en &&  inport_sel) in1_q <= inport_data;
            if (mem_write && a16 == OUT_ADDR) out_q <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel_q)
            RD_RAM:         rd_data = ram_rdata;
            RD_IN0, RD_IN1: rd_data = port_rd_q;
            default:        rd_data = '0;
        endcase
    end

    assign outport = out_q;

endmodule

// File: tb/tb_mips_mem_io.sv
// Directed self-checking bench for mips_mem_io.
module tb_mips_mem_io;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wr_data, inport_data;
    logic        mem_write, inport_en, inport_sel;
    logic [31:0] rd_data, outport;

    int n_chk  = 0;
    int n_pass = 0;

    mips_mem_io dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wr_data     (wr_data),
        .mem_write   (mem_write),
        .inport_data (inport_data),
        .inport_en   (inport_en),
        .inport_sel  (inport_sel),
        .rd_data     (rd_data),
        .outport     (outport)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; addr = 32'h0; wr_data = 32'h0; mem_write = 1'b0;
        inport_data = 32'h0; inport_en = 1'b0; inport_sel = 1'b0;

        tick();
        chk("reset_rd", rd_data, 32'h0);
        chk("reset_out", outport, 32'h0);
        tick();
        rst = 1'b0;
        addr = 32'hFFF0;
        tick();
        chk("unmapped_rd", rd_data, 32'h0);

        // Establish known RAM contents of zero.
        mem_write = 1'b1;
        for (int i = 0; i < 256; i++) begin
            addr = 32'(i * 4);
            tick();
        end
        mem_write = 1'b0;

        addr = 32'h10; wr_data = 32'hDEADBEEF; mem_write = 1'b1;
        tick();
        chk("wr_cycle_old", rd_data, 32'h0);
        mem_write = 1'b0;
        tick();
        chk("ram_rd_10", rd_data, 32'hDEADBEEF);
        addr = 32'h14;
        tick();
        chk("ram_rd_14", rd_data, 32'h0);

        addr = 32'h20; wr_data = 32'h11111111; mem_write = 1'b1;
        tick();
        wr_data = 32'h22222222;
        tick();
        chk("rfw_old", rd_data, 32'h11111111);
        mem_write = 1'b0;
        tick();
        chk("rfw_new", rd_data, 32'h22222222);

        inport_en = 1'b1; inport_sel = 1'b0; inport_data = 32'h1FF;
        tick();
        inport_sel = 1'b1; inport_data = 32'h0A5;
        tick();
        inport_en = 1'b0;
        addr = 32'hFFF8;
        tick();
        chk("in0_rd", rd_data, 32'h1FF);
        addr = 32'hFFFC;
        tick();
        chk("in1_rd", rd_data, 32'h0A5);

        addr = 32'hFFF8; inport_en = 1'b1; inport_sel = 1'b0; inport_data = 32'h077;
        tick();
        chk("in0_precap", rd_data, 32'h1FF);
        inport_en = 1'b0;
        tick();
        chk("in0_reload", rd_data, 32'h077);
        addr = 32'hFFFC;
        tick();
        chk("in1_hold", rd_data, 32'h0A5);

        wr_data = 32'h00000123; mem_write = 1'b1;
        tick();
        chk("outport_wr", outport, 32'h123);
        chk("shared_rd_in1", rd_data, 32'h0A5);
        mem_write = 1'b0;
        tick();
        chk("in1_after_out", rd_data, 32'h0A5);

        addr = 32'hFFF8; wr_data = 32'h00000BAD; mem_write = 1'b1;
        tick();
        chk("wr_in0_out", outport, 32'h123);
        mem_write = 1'b0;
        tick();
        chk("wr_in0_ign", rd_data, 32'h077);

        addr = 32'h8000; wr_data = 32'h0000CAFE; mem_write = 1'b1;
        tick();
        chk("unmapped_wr_rd", rd_data, 32'h0);
        mem_write = 1'b0;
        addr = 32'h0;
        tick();
        chk("ram0_intact", rd_data, 32'h0);
        chk("out_intact", outport, 32'h123);
        addr = 32'h0001_0013;
        tick();
        chk("hi_bits_ign", rd_data, 32'hDEADBEEF);

        rst = 1'b1; addr = 32'hFFFC; wr_data = 32'hFFFFFFFF; mem_write = 1'b1;
        tick();
        chk("rst_wr_out", outport, 32'h0);
        chk("rst_wr_rd", rd_data, 32'h0);
        rst = 1'b0; mem_write = 1'b0;
        tick();
        chk("rst_in1", rd_data, 32'h0);
        addr = 32'hFFF8;
        tick();
        chk("rst_in0", rd_data, 32'h0);
        addr = 32'h10;
        tick();
        chk("ram_survives", rd_data, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
